// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl -- asynchronous SRAM controller with a four-phase access sequence
// (IDLE -> SETUP -> ACCESS x WAIT_CYC -> HOLD -> IDLE).
//
// A request is accepted on the rising edge on which the FSM leaves IDLE. That
// edge latches we, the address (into mem_addr) and wdata (into dW). All three
// stay frozen until the transaction finishes. Every SRAM-facing output is
// registered. Each one is loaded from the strobe pattern of the state being
// entered, so the strobes change cleanly on clock edges and RW never overlaps
// an active output enable.
//
// Parameters
//   ADDR_W   SRAM word-address width (default 18)
//   WAIT_CYC ACCESS-phase length in clk cycles, 1..15 (default 2)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req, we, addr, wdata transaction request (level), direction, address, data
//   rdata               registered read data, held until the next read completes
//   ack                 one-cycle completion pulse, high during HOLD
//   busy                high whenever the FSM is not in IDLE
//   mem_addr, dW, RW    SRAM address, write data and bus-separator drive enable
//   dR                  data returned from the bus separator
//   mem_ce_n/oe_n/we_n  active-low SRAM strobes
//
// Optional feature (macro SRAM_CTRL_AUTOINC_EN):
//   ptr_mode (in)       1 = take the address from the internal pointer
//   ptr (out)           pointer, loaded with used address + 1 on completion
// -----------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
`ifdef SRAM_CTRL_AUTOINC_EN
    input  logic              ptr_mode,
    output logic [ADDR_W-1:0] ptr,
`endif
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       dW,
    output logic              RW,
    input  logic [15:0]       dR,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYC - 1);

    state_t            state, next_state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              cur_we;
    logic              last_access;
    logic [ADDR_W-1:0] sel_addr;

    logic              ce_n_d, oe_n_d, we_n_d, rw_d, ack_d;

    // Address source for a new request.
`ifdef SRAM_CTRL_AUTOINC_EN
    assign sel_addr = ptr_mode ? ptr : addr;
`else
    assign sel_addr = addr;
`endif

    assign last_access = (cnt == CNT_LAST);
    assign busy        = (state != IDLE);

    // In IDLE the direction comes straight from the request, because the
    // strobes for SETUP are loaded on the same edge that accepts it.
    assign cur_we = (state == IDLE) ? we : we_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req)         next_state = SETUP;
            SETUP:                    next_state = ACCESS;
            ACCESS:  if (last_access) next_state = HOLD;
            HOLD:                     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase

        // Strobe pattern of the state being entered.
        ce_n_d = (next_state == IDLE);
        rw_d   = (next_state != IDLE) && cur_we;
        we_n_d = !((next_state == ACCESS) && cur_we);
        oe_n_d = !(((next_state == SETUP) || (next_state == ACCESS)) && !cur_we);
        ack_d  = (next_state == HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            mem_addr <= '0;
            dW       <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
            RW       <= 1'b0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
        end else begin
            state    <= next_state;
            ack      <= ack_d;
            RW       <= rw_d;
            mem_ce_n <= ce_n_d;
            mem_oe_n <= oe_n_d;
            mem_we_n <= we_n_d;

            // Latch the transaction on the acceptance edge only.
            if (state == IDLE && req) begin
                we_q     <= we;
                mem_addr <= sel_addr;
                dW       <= wdata;
            end

            // The counter clears on entering SETUP and advances through ACCESS.
            // It stops at WAIT_CYC-1 on the edge that moves the FSM to HOLD.
            if (next_state == SETUP) begin
                cnt <= '0;
            end else if (state == ACCESS && !last_access) begin
                cnt <= cnt + 4'd1;
            end

            // Read data is sampled at the end of the final ACCESS cycle,
            // while the output enable is still asserted.
            if (state == ACCESS && last_access && !we_q) begin
                rdata <= dR;
            end
        end
    end

`ifdef SRAM_CTRL_AUTOINC_EN
    // The pointer follows the address actually used. Natural overflow of the
    // ADDR_W-bit sum wraps the top address back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == HOLD) begin
            ptr <= mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl -- directed, table-driven bench for sram_ctrl (WAIT_CYC = 2).
// Cycle numbering: the acceptance edge starts cycle 1 (SETUP). Cycles 2..W+1
// are ACCESS, cycle W+2 is HOLD (ack), and the cycle after that is IDLE.
// A small SRAM model behind the bus separator supplies dR.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

    localparam int AW = 18;
    localparam int W  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req, we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
    logic          ack, busy;
    logic [AW-1:0] mem_addr;
    logic [15:0]   dW;
    logic          RW;
    logic [15:0]   dR;
    logic          mem_ce_n, mem_oe_n, mem_we_n;
`ifdef SRAM_CTRL_AUTOINC_EN
    logic          ptr_mode;
    logic [AW-1:0] ptr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(AW), .WAIT_CYC(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
`ifdef SRAM_CTRL_AUTOINC_EN
        .ptr_mode (ptr_mode),
        .ptr      (ptr),
`endif
        .rdata    (rdata),
        .ack      (ack),
        .busy     (busy),
        .mem_addr (mem_addr),
        .dW       (dW),
        .RW       (RW),
        .dR       (dR),
        .mem_ce_n (mem_ce_n),
        .mem_oe_n (mem_oe_n),
        .mem_we_n (mem_we_n)
    );

    // SRAM model: 256 words, aliased on the low address byte.
    logic [15:0] mem [256] = '{default: 16'h0000};

    always @(posedge clk) begin
        if (!mem_ce_n && !mem_we_n && RW) mem[mem_addr[7:0]] <= dW;
    end

    always_comb dR = (!mem_ce_n && !mem_oe_n) ? mem[mem_addr[7:0]] : 16'h0000;

    // Bus-contention monitor, active for the whole run.
    always @(negedge clk) begin
        if (RW === 1'b1 && mem_oe_n === 1'b0) begin
            errors++;
            $display("FAIL bus_contention: RW=%b oe_n=%b required not both active", RW, mem_oe_n);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {busy, ack, ce_n, oe_n, we_n, RW} in cycle k (0 = IDLE).
    function automatic logic [5:0] exp_status(input int k, input logic w);
        logic act, acc, rd_en;
        act   = (k != 0);
        acc   = (k >= 2) && (k <= W + 1);
        rd_en = act && (k <= W + 1) && !w;
        return {act, (k == W + 2), !act, !rd_en, !(w && acc), (w && act)};
    endfunction

    task automatic check_phase(input string tag, input int k, input logic w,
                               input logic [AW-1:0] ea, input logic [15:0] ed);
        check($sformatf("%s.status[%0d]", tag, k),
              64'({busy, ack, mem_ce_n, mem_oe_n, mem_we_n, RW}), 64'(exp_status(k, w)));
        if (k != 0)
            check($sformatf("%s.addr_data[%0d]", tag, k), 64'({mem_addr, dW}), 64'({ea, ed}));
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_addr;
        logic [15:0]   wdata;
        logic [15:0]   exp_rdata;
    } vec_t;

    task automatic run_txn(input string tag, input vec_t v);
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            check_phase(tag, k, v.we, v.exp_addr, v.wdata);
            if (k == W + 2) check({tag, ".rdata"}, 64'(rdata), 64'(v.exp_rdata));
        end
        @(negedge clk);
        check_phase(tag, 0, v.we, v.exp_addr, v.wdata);
    endtask

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 18'h00010, 18'h00010, 16'hA5A5, 16'h0000};
        vecs[1] = '{1'b0, 18'h00010, 18'h00010, 16'h1111, 16'hA5A5};
        vecs[2] = '{1'b1, 18'h3FFFF, 18'h3FFFF, 16'h1234, 16'hA5A5};
        vecs[3] = '{1'b1, 18'h00020, 18'h00020, 16'h0F0F, 16'hA5A5};
        vecs[4] = '{1'b0, 18'h3FFFF, 18'h3FFFF, 16'h0000, 16'h1234};
        vecs[5] = '{1'b0, 18'h00020, 18'h00020, 16'hFFFF, 16'h0F0F};
        vecs[6] = '{1'b0, 18'h00055, 18'h00055, 16'h2222, 16'h0000};

        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef SRAM_CTRL_AUTOINC_EN
        ptr_mode = 1'b0;
`endif
        rst_n = 1'b0;
        #23;
        check("reset.status", 64'({busy, ack, mem_ce_n, mem_oe_n, mem_we_n, RW}), 64'(6'b001110));
        check("reset.regs", 64'({mem_addr, dW, rdata}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // req held high: requests changed while busy are ignored, and the
        // second SETUP follows a single IDLE cycle after HOLD.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 18'h00030; wdata = 16'hBEEF;
        @(posedge clk);
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            check_phase("held.first", k, 1'b1, 18'h00030, 16'hBEEF);
            if (k == 2) begin we = 1'b0; addr = 18'h00099; wdata = 16'h0000; end
            if (k == W + 2) addr = 18'h00030;
        end
        @(negedge clk);
        check_phase("held.gap", 0, 1'b1, 18'h00030, 16'hBEEF);
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            check_phase("held.second", k, 1'b0, 18'h00030, 16'h0000);
            if (k == W + 2) check("held.rdata", 64'(rdata), 64'(16'hBEEF));
        end

        // A req pulse during ACCESS of an already accepted transaction is ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 18'h00050; wdata = 16'h1111;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            check_phase("pulse", k, 1'b1, 18'h00050, 16'h1111);
            if (k == 2) begin req = 1'b1; addr = 18'h00077; end
            if (k == 3) req = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("pulse.idle[%0d]", k), 64'({busy, ack, mem_ce_n}), 64'(3'b001));
        end

        // Reset during write ACCESS aborts with no ack; then a read succeeds.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 18'h00040; wdata = 16'hDEAD;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.in_access", 64'({mem_we_n, RW}), 64'(2'b01));
        #2 rst_n = 1'b0;
        #1;
        check("abort.status", 64'({busy, ack, mem_ce_n, mem_oe_n, mem_we_n, RW}), 64'(6'b001110));
        check("abort.regs", 64'({mem_addr, dW, rdata}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            check($sformatf("abort.no_ack[%0d]", k), 64'({busy, ack}), 64'(2'b00));
        end
        run_txn("after_abort", '{1'b0, 18'h00010, 18'h00010, 16'h0000, 16'hA5A5});

`ifdef SRAM_CTRL_AUTOINC_EN
        run_txn("ptr.load", '{1'b1, 18'h3FFFF, 18'h3FFFF, 16'h0101, 16'hA5A5});
        check("ptr.wrap", 64'(ptr), 64'(18'h00000));
        ptr_mode = 1'b1;
        run_txn("ptr.w0", '{1'b1, 18'h01234, 18'h00000, 16'h0202, 16'hA5A5});
        run_txn("ptr.w1", '{1'b1, 18'h01234, 18'h00001, 16'h0303, 16'hA5A5});
        check("ptr.final", 64'(ptr), 64'(18'h00002));
        ptr_mode = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
